// File: rtl/falling_pkg.sv
// ---------------------------------------------------------------------------
// falling_pkg
//   Shared definitions for the falling-object spawner:
//   - screen geometry and the speed fixed-point scale;
//   - spawner FSM state encoding, as plain constants plus an enum built on them;
//   - the 16-bit Galois LFSR step, polynomial mask 0xB400.
// ---------------------------------------------------------------------------
package falling_pkg;

   localparam int FIXED_POINT_MULTIPLIER = 64;
   localparam int X_FRAME_SIZE           = 639;
   localparam int Y_FRAME_SIZE           = 479;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_WAIT   = 2'd1;
   localparam logic [1:0] ST_LOAD   = 2'd2;
   localparam logic [1:0] ST_ACTIVE = 2'd3;

   typedef enum logic [1:0] {
      IDLE   = ST_IDLE,
      WAIT   = ST_WAIT,
      LOAD   = ST_LOAD,
      ACTIVE = ST_ACTIVE
   } spawner_state_t;

   localparam logic [15:0] LFSR_POLY = 16'hB400;

   // Galois form: shift right, fold the polynomial in when a 1 drops out.
   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
   endfunction

endpackage

// File: rtl/lfsr_16.sv
// ---------------------------------------------------------------------------
// lfsr_16
//   Free-running 16-bit Galois LFSR (mask 0xB400). Loads SEED on reset and
//   advances one step on every clock where reset is low.
//   Ports:
//     clk     in   1   clock
//     reset   in   1   synchronous, active-high
//     state_o out  16  current LFSR state
// ---------------------------------------------------------------------------
module lfsr_16
   import falling_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        reset,
   output logic [15:0] state_o
);

   logic [15:0] state_q;
   logic [15:0] state_d;

   assign state_d = lfsr_next(state_q);
   assign state_o = state_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= SEED;
      end else begin
         state_q <= state_d;
      end
   end

endmodule

// File: rtl/falling_object_spawner.sv
// ---------------------------------------------------------------------------
// falling_object_spawner
//   Drives one falling-object mover: waits SPAWN_DELAY_FRAMES frames, picks a
//   pseudo-random X in [X_MIN, X_MAX], pulses load, keeps visible high while
//   the object falls, and retires it on collision (caught, speeds up) or on
//   exceed (escaped). All outputs are registered.
//
//   Handshake: there is no valid/ready pair here. load, caught and escaped
//   are single-cycle pulses that the consumer must take on the cycle they are
//   high; exceed and collision are sampled only while ACTIVE.
//
//   Ports:
//     clk          in   1   clock
//     reset        in   1   synchronous, active-high
//     startOfFrame in   1   one-cycle pulse per frame
//     enable       in   1   spawning allowed
//     collision    in   1   object hit this cycle
//     exceed       in   1   object reached the bottom of the frame
//     load         out  1   pulse: mover latches X and resets Y
//     visible      out  1   object on screen
//     speed        out  32  signed fall speed (64 = 1 px/frame)
//     topLeftXRand out  11  signed spawn X, valid while load is high
//     caught       out  1   pulse: retired by collision
//     escaped      out  1   pulse: retired by exceed
//     spawnCount   out  16  launches since reset, wrapping
//     state_o      out  2   current FSM state (debug)
// ---------------------------------------------------------------------------
module falling_object_spawner
   import falling_pkg::*;
#(
   parameter int          X_MIN              = 0,
   parameter int          X_MAX              = 600,
   parameter int          SPAWN_DELAY_FRAMES = 60,
   parameter int          INITIAL_SPEED      = 64,
   parameter int          SPEED_STEP         = 16,
   parameter int          MAX_SPEED          = 512,
   parameter logic [15:0] LFSR_SEED          = 16'hACE1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               startOfFrame,
   input  logic               enable,
   input  logic               collision,
   input  logic               exceed,
   output logic               load,
   output logic               visible,
   output logic signed [31:0] speed,
   output logic signed [10:0] topLeftXRand,
   output logic               caught,
   output logic               escaped,
   output logic [15:0]        spawnCount,
   output spawner_state_t     state_o
);

   localparam int          X_SPAN     = X_MAX - X_MIN + 1;
   localparam logic [15:0] FRAME_LAST = 16'(SPAWN_DELAY_FRAMES - 1);

   spawner_state_t     state_q, state_d;
   logic [15:0]        frame_q, frame_d;
   logic               load_q, load_d;
   logic               visible_q, visible_d;
   logic               caught_q, caught_d;
   logic               escaped_q, escaped_d;
   logic signed [31:0] speed_q, speed_d;
   logic signed [10:0] x_q, x_d;
   logic [15:0]        count_q, count_d;

   logic [15:0]        lfsr_state;
   logic [31:0]        x_off;
   logic signed [31:0] x_spawn;
   logic signed [31:0] speed_sum;
   logic signed [31:0] speed_sat;
   logic               unused_hi_bits;

   lfsr_16 #(
      .SEED(LFSR_SEED)
   ) u_lfsr (
      .clk    (clk),
      .reset  (reset),
      .state_o(lfsr_state)
   );

   // Spawn X from the low 11 LFSR bits; divisor is a constant so this maps
   // to a fixed modulo, and the result always lands inside [X_MIN, X_MAX].
   assign x_off   = 32'({5'd0, lfsr_state[10:0]}) % 32'(X_SPAN);
   assign x_spawn = X_MIN + $signed(x_off);

   assign speed_sum = speed_q + 32'(SPEED_STEP);
   assign speed_sat = (speed_sum > 32'(MAX_SPEED)) ? 32'(MAX_SPEED) : speed_sum;

   assign unused_hi_bits = ^{lfsr_state[15:11], x_spawn[31:11]};

   always_comb begin
      state_d   = state_q;
      frame_d   = frame_q;
      load_d    = 1'b0;
      visible_d = visible_q;
      caught_d  = 1'b0;
      escaped_d = 1'b0;
      speed_d   = speed_q;
      x_d       = x_q;
      count_d   = count_q;

      case (state_q)
         IDLE: begin
            visible_d = 1'b0;
            if (enable) begin
               state_d = WAIT;
               frame_d = '0;
            end
         end
         WAIT: begin
            visible_d = 1'b0;
            if (!enable) begin
               state_d = IDLE;
            end else if (startOfFrame) begin
               if (frame_q == FRAME_LAST) begin
                  x_d     = x_spawn[10:0];
                  load_d  = 1'b1;
                  count_d = count_q + 16'd1;
                  state_d = LOAD;
               end else begin
                  frame_d = frame_q + 16'd1;
               end
            end
         end
         LOAD: begin
            // visible rises one cycle after load so the mover never sees a
            // frame update competing with the load on the same cycle.
            visible_d = 1'b1;
            state_d   = ACTIVE;
         end
         ACTIVE: begin
            if (collision || exceed) begin
               visible_d = 1'b0;
               frame_d   = '0;
               state_d   = enable ? WAIT : IDLE;
               if (collision) begin
                  caught_d = 1'b1;
                  speed_d  = speed_sat;
               end else begin
                  escaped_d = 1'b1;
               end
            end
         end
         default: begin
            state_d   = IDLE;
            visible_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         frame_q   <= '0;
         load_q    <= 1'b0;
         visible_q <= 1'b0;
         caught_q  <= 1'b0;
         escaped_q <= 1'b0;
         speed_q   <= 32'(INITIAL_SPEED);
         x_q       <= 11'(X_MIN);
         count_q   <= '0;
      end else begin
         state_q   <= state_d;
         frame_q   <= frame_d;
         load_q    <= load_d;
         visible_q <= visible_d;
         caught_q  <= caught_d;
         escaped_q <= escaped_d;
         speed_q   <= speed_d;
         x_q       <= x_d;
         count_q   <= count_d;
      end
   end

   assign load         = load_q;
   assign visible      = visible_q;
   assign caught       = caught_q;
   assign escaped      = escaped_q;
   assign speed        = speed_q;
   assign topLeftXRand = x_q;
   assign spawnCount   = count_q;
   assign state_o      = state_q;

endmodule

// File: tb/tb_falling_object_spawner.sv
module tb_falling_object_spawner;

   localparam int          P_X_MIN  = 10;
   localparam int          P_X_MAX  = 20;
   localparam int          P_DELAY  = 3;
   localparam int          P_SPEED0 = 64;
   localparam int          P_STEP   = 100;
   localparam int          P_MAX    = 512;
   localparam logic [15:0] P_SEED   = 16'hACE1;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               reset = 1'b1;
   logic               startOfFrame = 1'b0;
   logic               enable = 1'b0;
   logic               collision = 1'b0;
   logic               exceed = 1'b0;
   logic               load;
   logic               visible;
   logic signed [31:0] speed;
   logic signed [10:0] topLeftXRand;
   logic               caught;
   logic               escaped;
   logic [15:0]        spawnCount;
   logic [1:0]         unused_state;

   falling_object_spawner #(
      .X_MIN             (P_X_MIN),
      .X_MAX             (P_X_MAX),
      .SPAWN_DELAY_FRAMES(P_DELAY),
      .INITIAL_SPEED     (P_SPEED0),
      .SPEED_STEP        (P_STEP),
      .MAX_SPEED         (P_MAX),
      .LFSR_SEED         (P_SEED)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .startOfFrame(startOfFrame),
      .enable      (enable),
      .collision   (collision),
      .exceed      (exceed),
      .load        (load),
      .visible     (visible),
      .speed       (speed),
      .topLeftXRand(topLeftXRand),
      .caught      (caught),
      .escaped     (escaped),
      .spawnCount  (spawnCount),
      .state_o     (unused_state)
   );

   // ---------------- reference model ----------------
   int          checks = 0;
   int          errors = 0;
   int          exp_speed = P_SPEED0;
   logic [15:0] exp_count = 16'd0;
   bit          seen_x[P_X_MAX-P_X_MIN+1];
   logic [15:0] m_lfsr;

   function automatic logic [15:0] galois_step(input logic [15:0] s);
      logic [15:0] fb;
      fb = s[0] ? 16'hB400 : 16'h0000;
      return (s >> 1) ^ fb;
   endfunction

   // Random source advances on every non-reset clock, reseeded by reset.
   always @(posedge clk) begin
      if (reset) m_lfsr <= P_SEED;
      else       m_lfsr <= galois_step(m_lfsr);
   end

   function automatic int min_int(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic frame_pulse();
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      startOfFrame = 1'b0;
      collision = 1'b0;
      exceed = 1'b0;
      repeat (2) tick();
      reset = 1'b0;
      exp_speed = P_SPEED0;
      exp_count = 16'd0;
   endtask

   // Expects the DUT in WAIT with an empty frame count.
   task automatic do_launch(input bit reset_in_load);
      int exp_x;
      int gap;
      exp_x = 0;
      for (int f = 0; f < P_DELAY; f++) begin
         gap = $urandom_range(0, 3);
         repeat (gap) begin
            tick();
            checks++;
            if (load !== 1'b0) begin
               errors++;
               $display("FAIL launch_gap_load: got %b expected 0", load);
            end
         end
         if (f == P_DELAY - 1) exp_x = P_X_MIN + (int'(m_lfsr[10:0]) % (P_X_MAX - P_X_MIN + 1));
         frame_pulse();
         if (f < P_DELAY - 1) begin
            checks++;
            if (load !== 1'b0) begin
               errors++;
               $display("FAIL early_load: frame %0d got %b expected 0", f, load);
            end
         end else begin
            checks++;
            if (load !== 1'b1 || visible !== 1'b0) begin
               errors++;
               $display("FAIL load_pulse: load=%b visible=%b expected 1 0", load, visible);
            end
            checks++;
            if (topLeftXRand !== 11'(exp_x)) begin
               errors++;
               $display("FAIL spawn_x: got %0d expected %0d", topLeftXRand, exp_x);
            end
            if (topLeftXRand >= P_X_MIN && topLeftXRand <= P_X_MAX)
               seen_x[int'(topLeftXRand) - P_X_MIN] = 1'b1;
            exp_count = exp_count + 16'd1;
            checks++;
            if (spawnCount !== exp_count) begin
               errors++;
               $display("FAIL spawn_count: got %0d expected %0d", spawnCount, exp_count);
            end
         end
      end
      if (reset_in_load) begin
         reset = 1'b1;
         tick();
         reset = 1'b0;
         exp_count = 16'd0;
         exp_speed = P_SPEED0;
         checks++;
         if (load !== 1'b0 || spawnCount !== 16'd0 || visible !== 1'b0 || speed !== exp_speed) begin
            errors++;
            $display("FAIL reset_in_load: load=%b count=%0d visible=%b speed=%0d expected 0 0 0 %0d",
                     load, spawnCount, visible, speed, exp_speed);
         end
      end else begin
         tick();
         checks++;
         if (load !== 1'b0 || visible !== 1'b1) begin
            errors++;
            $display("FAIL visible_rise: load=%b visible=%b expected 0 1", load, visible);
         end
      end
   endtask

   // kind: 0 = exceed, 1 = collision, 2 = both in the same cycle.
   task automatic do_retire(input int kind, input int flight);
      for (int i = 0; i < flight; i++) begin
         startOfFrame = 1'($urandom_range(0, 1));
         tick();
         startOfFrame = 1'b0;
         checks++;
         if (visible !== 1'b1 || caught !== 1'b0 || escaped !== 1'b0 || speed !== exp_speed) begin
            errors++;
            $display("FAIL flight: visible=%b caught=%b escaped=%b speed=%0d expected 1 0 0 %0d",
                     visible, caught, escaped, speed, exp_speed);
         end
      end
      collision = (kind != 0);
      exceed    = (kind != 1);
      tick();
      collision = 1'b0;
      exceed    = 1'b0;
      if (kind != 0) exp_speed = min_int(exp_speed + P_STEP, P_MAX);
      checks++;
      if (caught !== (kind != 0) || escaped !== (kind == 0) || visible !== 1'b0 || speed !== exp_speed) begin
         errors++;
         $display("FAIL retire kind %0d: caught=%b escaped=%b visible=%b speed=%0d expected %b %b 0 %0d",
                  kind, caught, escaped, visible, speed, kind != 0, kind == 0, exp_speed);
      end
      tick();
      checks++;
      if (caught !== 1'b0 || escaped !== 1'b0 || visible !== 1'b0 || load !== 1'b0) begin
         errors++;
         $display("FAIL retire_pulse_width: caught=%b escaped=%b visible=%b load=%b expected 0 0 0 0",
                  caught, escaped, visible, load);
      end
   endtask

   task automatic quiet_frames(input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         frame_pulse();
         tick();
         checks++;
         if (load !== 1'b0 || visible !== 1'b0) begin
            errors++;
            $display("FAIL %s: load=%b visible=%b expected 0 0", tag, load, visible);
         end
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      apply_reset();
      checks++;
      if (load !== 1'b0 || visible !== 1'b0 || caught !== 1'b0 || escaped !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags: load=%b visible=%b caught=%b escaped=%b expected 0 0 0 0",
                  load, visible, caught, escaped);
      end
      checks++;
      if (speed !== P_SPEED0 || topLeftXRand !== 11'(P_X_MIN) || spawnCount !== 16'd0) begin
         errors++;
         $display("FAIL reset_values: speed=%0d x=%0d count=%0d expected %0d %0d 0",
                  speed, topLeftXRand, spawnCount, P_SPEED0, P_X_MIN);
      end
      quiet_frames(4, "idle_no_spawn");
   endtask

   task automatic test_first_launch();
      enable = 1'b1;
      tick();
      do_launch(1'b0);
   endtask

   task automatic test_exceed();
      do_retire(0, 3);
      do_launch(1'b0);
      do_retire(0, 1);
   endtask

   task automatic test_catches();
      int speed_tbl[6];
      speed_tbl = '{164, 264, 364, 464, 512, 512};
      for (int i = 0; i < 6; i++) begin
         do_launch(1'b0);
         do_retire(1, $urandom_range(0, 4));
         checks++;
         if (speed !== speed_tbl[i]) begin
            errors++;
            $display("FAIL catch_speed %0d: got %0d expected %0d", i, speed, speed_tbl[i]);
         end
      end
   endtask

   task automatic test_both();
      apply_reset();
      enable = 1'b1;
      tick();
      do_launch(1'b0);
      do_retire(2, 2);
      checks++;
      if (speed !== 164) begin
         errors++;
         $display("FAIL both_speed: got %0d expected 164", speed);
      end
   endtask

   task automatic test_enable();
      frame_pulse();
      enable = 1'b0;
      tick();
      quiet_frames(5, "wait_abort");
      enable = 1'b1;
      tick();
      do_launch(1'b0);
      enable = 1'b0;
      do_retire(0, 6);
      quiet_frames(5, "active_then_idle");
      enable = 1'b1;
      tick();
   endtask

   task automatic test_x_range();
      bit all_seen;
      for (int i = 0; i < P_X_MAX - P_X_MIN + 1; i++) seen_x[i] = 1'b0;
      for (int n = 0; n < 1000; n++) begin
         do_launch(1'b0);
         checks++;
         if (topLeftXRand < P_X_MIN || topLeftXRand > P_X_MAX) begin
            errors++;
            $display("FAIL x_range: got %0d expected within [%0d,%0d]", topLeftXRand, P_X_MIN, P_X_MAX);
         end
         do_retire($urandom_range(0, 2), $urandom_range(0, 4));
      end
      all_seen = 1'b1;
      for (int i = 0; i < P_X_MAX - P_X_MIN + 1; i++) if (!seen_x[i]) all_seen = 1'b0;
      checks++;
      if (!all_seen) begin
         errors++;
         $display("FAIL x_coverage: got %b expected 1 (all X values seen)", all_seen);
      end
   endtask

   task automatic test_reset_in_load();
      do_launch(1'b1);
      tick();
      do_launch(1'b0);
      do_retire(1, 1);
   endtask

   // ---------------- main sequence + report ----------------
   initial begin
      test_reset();
      test_first_launch();
      test_exceed();
      test_catches();
      test_both();
      test_enable();
      test_x_range();
      test_reset_in_load();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
